// File: rtl/arcade_input_mapper.sv
// Player-input front end: debounced DB9 pins merged with keyboard controls, port routing,
// coin pulse stretching and the scandoubler toggle. Define AUTOFIRE_EN to build autofire on button 0.
module arcade_input_mapper #(
    parameter int   PLAYERS           = 2,
    parameter int   BUTTONS           = 2,
    parameter int   DEBOUNCE_CYCLES   = 1024,
    parameter int   COIN_PULSE_CYCLES = 65536,
    parameter int   AUTOFIRE_CYCLES   = 1048576,
    parameter logic SCAN_DEFAULT      = 1'b0
) (
    input  logic                           clk_sys,
    input  logic                           reset,
    input  logic [PLAYERS*(4+BUTTONS)-1:0] joy_n_i,
    input  logic [PLAYERS*(4+BUTTONS)-1:0] kbd_player_i,
    input  logic [PLAYERS-1:0]             kbd_coin_i,
    input  logic [PLAYERS-1:0]             kbd_start_i,
    input  logic                           toggle_scan_i,
    input  logic                           joyswap_i,
    input  logic                           oneplayer_i,
    input  logic                           autofire_i,
    output logic [PLAYERS*(4+BUTTONS)-1:0] player_o,
    output logic [PLAYERS-1:0]             coin_o,
    output logic [PLAYERS-1:0]             start_o,
    output logic                           scandoubler_disable_o
);

    localparam int W  = 4 + BUTTONS;
    localparam int N  = PLAYERS * W;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int CW = $clog2(COIN_PULSE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] COIN_LAST = CW'(COIN_PULSE_CYCLES - 1);

    localparam logic [1:0] COIN_IDLE  = 2'd0;
    localparam logic [1:0] COIN_PULSE = 2'd1;
    localparam logic [1:0] COIN_WAIT  = 2'd2;

    logic [DW-1:0]      presc;
    logic               tick;
    logic [N-1:0]       joy_s1, joy_s2, hist_1, hist_2, stable_n;
    logic [N-1:0]       phys, swapped, routed, merged, final_player;
    logic [PLAYERS-1:0] coin_r, coin_prev;
    logic [1:0]         coin_state [PLAYERS];
    logic [CW-1:0]      coin_cnt   [PLAYERS];
    logic               scan_s1, scan_s2, scan_prev;

    assign tick = (presc == DB_LAST);
    assign phys = ~stable_n;

    // History holds the last two tick samples; the live synchronised value is the third entry.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            joy_s1   <= '1;
            joy_s2   <= '1;
            hist_1   <= '1;
            hist_2   <= '1;
            stable_n <= '1;
        end else begin
            presc  <= tick ? '0 : presc + 1'b1;
            joy_s1 <= joy_n_i;
            joy_s2 <= joy_s1;
            if (tick) begin
                hist_1   <= joy_s2;
                hist_2   <= hist_1;
                stable_n <= (joy_s2 & hist_1 & hist_2) | (stable_n & (joy_s2 | hist_1 | hist_2));
            end
        end
    end

    always_comb begin
        swapped = '0;
        for (int k = 0; k < PLAYERS; k++) begin
            if (joyswap_i && PLAYERS >= 2 && k < 2)
                swapped[k*W +: W] = phys[(1-k)*W +: W];
            else
                swapped[k*W +: W] = phys[k*W +: W];
        end
    end

    always_comb begin
        routed = swapped;
        if (oneplayer_i) begin
            for (int k = 1; k < PLAYERS; k++)
                routed[0 +: W] = routed[0 +: W] | swapped[k*W +: W];
        end
    end

    assign merged = routed | kbd_player_i;

`ifdef AUTOFIRE_EN
    localparam int AW = $clog2(AUTOFIRE_CYCLES + 1);
    localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_CYCLES - 1);

    logic [AW-1:0]      af_cnt [PLAYERS];
    logic [PLAYERS-1:0] af_tog;
    logic [PLAYERS-1:0] af_active;

    always_comb begin
        af_active = '0;
        for (int p = 0; p < PLAYERS; p++)
            af_active[p] = autofire_i & merged[p*W + 4];
    end

    // Toggle idles high so a fresh press always starts with a full high phase.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            af_tog <= '1;
            for (int p = 0; p < PLAYERS; p++)
                af_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                if (!af_active[p]) begin
                    af_cnt[p] <= '0;
                    af_tog[p] <= 1'b1;
                end else if (af_cnt[p] == AF_LAST) begin
                    af_cnt[p] <= '0;
                    af_tog[p] <= ~af_tog[p];
                end else begin
                    af_cnt[p] <= af_cnt[p] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        final_player = merged;
        for (int p = 0; p < PLAYERS; p++)
            if (af_active[p])
                final_player[p*W + 4] = af_tog[p];
    end
`else
    localparam int autofire_cycles_unused = AUTOFIRE_CYCLES;
    logic autofire_unused;
    assign autofire_unused = autofire_i;
    assign final_player    = merged;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            player_o <= '0;
            start_o  <= '0;
        end else begin
            player_o <= final_player;
            start_o  <= kbd_start_i;
        end
    end

    // Coin keys are registered once before edge detection, giving the two-cycle rise latency.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            coin_r    <= '0;
            coin_prev <= '0;
            coin_o    <= '0;
            for (int p = 0; p < PLAYERS; p++) begin
                coin_state[p] <= COIN_IDLE;
                coin_cnt[p]   <= '0;
            end
        end else begin
            coin_r    <= kbd_coin_i;
            coin_prev <= coin_r;
            for (int p = 0; p < PLAYERS; p++) begin
                case (coin_state[p])
                    COIN_IDLE: begin
                        if (coin_r[p] && !coin_prev[p]) begin
                            coin_state[p] <= COIN_PULSE;
                            coin_cnt[p]   <= COIN_LAST;
                            coin_o[p]     <= 1'b1;
                        end
                    end
                    COIN_PULSE: begin
                        if (coin_cnt[p] == '0) begin
                            coin_state[p] <= COIN_WAIT;
                            coin_o[p]     <= 1'b0;
                        end else begin
                            coin_cnt[p] <= coin_cnt[p] - 1'b1;
                        end
                    end
                    COIN_WAIT: begin
                        if (!kbd_coin_i[p])
                            coin_state[p] <= COIN_IDLE;
                    end
                    default: begin
                        coin_state[p] <= COIN_IDLE;
                        coin_o[p]     <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            scan_s1               <= 1'b0;
            scan_s2               <= 1'b0;
            scan_prev             <= 1'b0;
            scandoubler_disable_o <= SCAN_DEFAULT;
        end else begin
            scan_s1   <= toggle_scan_i;
            scan_s2   <= scan_s1;
            scan_prev <= scan_s2;
            if (scan_s2 && !scan_prev)
                scandoubler_disable_o <= ~scandoubler_disable_o;
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: directed joystick, coin, scan and autofire cases
// followed by randomized keyboard/coin/scan traffic and randomized joystick holds with glitches.
module tb_arcade_input_mapper;

    localparam int C = 8;

    logic        clk_sys;
    logic        reset;
    logic [11:0] joy_n_i, kbd_player_i, player_o;
    logic [1:0]  kbd_coin_i, kbd_start_i, coin_o, start_o;
    logic        toggle_scan_i, joyswap_i, oneplayer_i, autofire_i, scandoubler_disable_o;

    int total = 0;
    int bad   = 0;

    arcade_input_mapper #(
        .PLAYERS(2), .BUTTONS(2), .DEBOUNCE_CYCLES(4), .COIN_PULSE_CYCLES(C),
        .AUTOFIRE_CYCLES(3), .SCAN_DEFAULT(1'b1)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .joy_n_i(joy_n_i), .kbd_player_i(kbd_player_i),
        .kbd_coin_i(kbd_coin_i), .kbd_start_i(kbd_start_i), .toggle_scan_i(toggle_scan_i),
        .joyswap_i(joyswap_i), .oneplayer_i(oneplayer_i), .autofire_i(autofire_i),
        .player_o(player_o), .coin_o(coin_o), .start_o(start_o),
        .scandoubler_disable_o(scandoubler_disable_o)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Staged inputs take effect at the next rising edge; outputs are then sampled 1 time unit later.
    task automatic applyStimulus();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference routing for two players of six bits each.
    function automatic logic [11:0] route(input logic [11:0] pins_n, input logic sw, input logic op);
        logic [5:0] port0, port1, pl0, pl1;
        port0 = ~pins_n[5:0];
        port1 = ~pins_n[11:6];
        pl0 = sw ? port1 : port0;
        pl1 = sw ? port0 : port1;
        if (op) pl0 = port0 | port1;
        return {pl1, pl0};
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          first;
        logic        exp_scan;
        logic [11:0] pins, mask;
        logic        sw, op;
        logic [1:0]  cv1, cv2, exp_coin;
        int          pst [2];
        int          pend [2];
        bit          rel [2];
        logic        t1, t2, t3;
        logic        exp_af;

        reset = 1'b1;
        joy_n_i = '1;
        kbd_player_i = '0;
        kbd_coin_i = '0;
        kbd_start_i = '0;
        toggle_scan_i = 1'b0;
        joyswap_i = 1'b0;
        oneplayer_i = 1'b0;
        autofire_i = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("rst_player", 32'(player_o), 32'd0);
        checkOutput("rst_coin", 32'(coin_o), 32'd0);
        checkOutput("rst_start", 32'(start_o), 32'd0);
        checkOutput("rst_scan", 32'(scandoubler_disable_o), 32'd1);
        exp_scan = 1'b1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput("idle_pins", 32'(player_o), 32'd0);
        end

        // Three-cycle glitch on player 0 right must be filtered.
        joy_n_i = 12'hFFE;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("glitch_hold", 32'(player_o), 32'd0);
        end
        joy_n_i = 12'hFFF;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            checkOutput("glitch_after", 32'(player_o), 32'd0);
        end

        joy_n_i = 12'hFFE;
        first = 0;
        for (int i = 1; i <= 15; i++) begin
            applyStimulus();
            if (first == 0 && player_o[0]) first = i;
        end
        checkOutput("joy_latency", (first >= 11 && first <= 15) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("joy_held", 32'(player_o), 32'h001);
        end
        joy_n_i = 12'hFFF;
        repeat (16) applyStimulus();
        checkOutput("joy_release", 32'(player_o), 32'd0);

        joy_n_i = ~12'h020;
        joyswap_i = 1'b1;
        repeat (16) applyStimulus();
        checkOutput("swap", 32'(player_o), 32'h800);
        oneplayer_i = 1'b1;
        applyStimulus();
        checkOutput("swap_oneplayer", 32'(player_o), 32'h820);
        joy_n_i = 12'hFFF;
        joyswap_i = 1'b0;
        oneplayer_i = 1'b0;
        repeat (16) applyStimulus();
        checkOutput("swap_release", 32'(player_o), 32'd0);

        // Held coin key: one pulse of C cycles, two cycles after the rise.
        for (int rep = 0; rep < 2; rep++) begin
            kbd_coin_i = 2'b10;
            for (int i = 1; i <= 30; i++) begin
                applyStimulus();
                checkOutput("coin_pulse", 32'(coin_o), (i >= 2 && i <= 1 + C) ? 32'd2 : 32'd0);
            end
            kbd_coin_i = 2'b00;
            for (int i = 0; i < 5; i++) begin
                applyStimulus();
                checkOutput("coin_released", 32'(coin_o), 32'd0);
            end
        end

        for (int pulse = 0; pulse < 3; pulse++) begin
            toggle_scan_i = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                applyStimulus();
                if (i == 3) exp_scan = ~exp_scan;
                checkOutput("scan_flip", 32'(scandoubler_disable_o), 32'(exp_scan));
                if (i == 2) toggle_scan_i = 1'b0;
            end
        end

        kbd_coin_i = 2'b01;
        repeat (4) applyStimulus();
        checkOutput("coin_before_rst", 32'(coin_o), 32'd1);
        #2;
        reset = 1'b1;
        kbd_coin_i = 2'b00;
        #1;
        checkOutput("rst_mid_coin", 32'(coin_o), 32'd0);
        checkOutput("rst_mid_scan", 32'(scandoubler_disable_o), 32'd1);
        exp_scan = 1'b1;
        applyStimulus();
        reset = 1'b0;

        autofire_i = 1'b1;
        kbd_player_i = 12'h010;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus();
`ifdef AUTOFIRE_EN
            exp_af = (((i - 1) / 3) % 2 == 0);
`else
            exp_af = 1'b1;
`endif
            checkOutput("autofire", 32'(player_o), exp_af ? 32'h010 : 32'h000);
        end
        kbd_player_i = '0;
        applyStimulus();
        checkOutput("autofire_release", 32'(player_o), 32'd0);
        autofire_i = 1'b0;

        // Randomized keyboard, start, coin and scan traffic against the timing model.
        cv1 = '0;
        cv2 = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pst[p] = -100;
            pend[p] = -100;
            rel[p] = 1'b1;
        end
        for (int n = 0; n < 300; n++) begin
            kbd_player_i = 12'($urandom);
            kbd_start_i = 2'($urandom);
            if ($urandom_range(0, 7) == 0) kbd_coin_i[0] = ~kbd_coin_i[0];
            if ($urandom_range(0, 7) == 0) kbd_coin_i[1] = ~kbd_coin_i[1];
            if ($urandom_range(0, 3) == 0) toggle_scan_i = ~toggle_scan_i;
            joyswap_i = 1'($urandom);
            oneplayer_i = 1'($urandom);
`ifndef AUTOFIRE_EN
            autofire_i = 1'($urandom);
`endif
            applyStimulus();
            for (int p = 0; p < 2; p++) begin
                if (cv1[p] && !cv2[p] && n >= pend[p] + 2 && rel[p]) begin
                    pst[p] = n;
                    pend[p] = n + C - 1;
                    rel[p] = 1'b0;
                end
                exp_coin[p] = (n >= pst[p] && n <= pend[p]);
                if (n >= pend[p] + 2 && !kbd_coin_i[p]) rel[p] = 1'b1;
            end
            if (t2 && !t3) exp_scan = ~exp_scan;
            t3 = t2;
            t2 = t1;
            t1 = toggle_scan_i;
            cv2 = cv1;
            cv1 = kbd_coin_i;
            checkOutput("rnd_player", 32'(player_o), 32'(kbd_player_i));
            checkOutput("rnd_start", 32'(start_o), 32'(kbd_start_i));
            checkOutput("rnd_coin", 32'(coin_o), 32'(exp_coin));
            checkOutput("rnd_scan", 32'(scandoubler_disable_o), 32'(exp_scan));
        end

        // Randomized joystick holds with routing modes and sub-tick glitches.
        kbd_player_i = '0;
        kbd_coin_i = '0;
        toggle_scan_i = 1'b0;
        autofire_i = 1'b0;
        for (int it = 0; it < 12; it++) begin
            pins = 12'($urandom);
            sw = 1'($urandom);
            op = 1'($urandom);
            joy_n_i = pins;
            joyswap_i = sw;
            oneplayer_i = op;
            repeat (16) applyStimulus();
            checkOutput("rnd_joy", 32'(player_o), 32'(route(pins, sw, op)));
            mask = 12'($urandom) | 12'h001;
            joy_n_i = pins ^ mask;
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                applyStimulus();
                checkOutput("rnd_glitch", 32'(player_o), 32'(route(pins, sw, op)));
            end
            joy_n_i = pins;
            for (int i = 0; i < 16; i++) begin
                applyStimulus();
                checkOutput("rnd_glitch_after", 32'(player_o), 32'(route(pins, sw, op)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
